// File: rtl/carregador_programa_pkg.sv
// Shared definitions for the instruction-memory program loader:
// loader FSM states and default memory geometry.
package pkg_carregador;

  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 32;
  localparam int WORD_W_DEF = 32;

  typedef enum logic [1:0] {
    OCIOSO,
    RECEBE,
    ESCREVE,
    FIM
  } estado_t;

endpackage

// File: rtl/carregador_programa_montador.sv
// Little-endian word assembler: byte k of each word lands in bits [8k+7:8k].
// word_cheia flags the transfer that completes the current word.
module montador_palavra (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        word_cheia,
  output logic [31:0] palavra_prox
);

  logic [1:0]  cont;
  logic [31:0] buffer;

  // palavra_prox already contains the byte being accepted, so the writer
  // can register the finished word on the same edge as the 4th transfer.
  always_comb begin
    palavra_prox = buffer;
    palavra_prox[{cont, 3'b000} +: 8] = byte_in;
    word_cheia = shift_en && (cont == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont   <= 2'd0;
      buffer <= 32'd0;
    end else if (clear) begin
      cont   <= 2'd0;
      buffer <= 32'd0;
    end else if (shift_en) begin
      cont   <= cont + 2'd1;
      buffer <= palavra_prox;
    end
  end

endmodule

// File: rtl/carregador_programa.sv
// Program loader: takes a byte stream, writes little-endian words to the
// instruction memory from address 0, and holds the CPU until the load is done.
module carregador_programa
  import pkg_carregador::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   n_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_endr,
  output logic [WORD_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              erro,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH_N = DEPTH[ADDR_W:0];

  estado_t           estado;
  logic [ADDR_W-1:0] indice;
  logic [ADDR_W:0]   n_latched;
  logic              transfer;
  logic              start_ok;
  logic              pode_iniciar;
  logic              ultimo;
  logic              word_cheia;
  logic [31:0]       palavra_prox;

  assign byte_ready   = (estado == RECEBE);
  assign transfer     = byte_valid && byte_ready;
  assign pode_iniciar = (estado == OCIOSO) || (estado == FIM);
  assign start_ok     = start && (n_words != '0) && (n_words <= DEPTH_N);
  assign ultimo       = ({1'b0, indice} == (n_latched - 1'b1));

  montador_palavra u_montador (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (pode_iniciar && start_ok),
    .shift_en     (transfer),
    .byte_in      (byte_in),
    .word_cheia   (word_cheia),
    .palavra_prox (palavra_prox)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      erro      <= 1'b0;
      mem_we    <= 1'b0;
      mem_endr  <= '0;
      mem_din   <= '0;
      checksum  <= '0;
      indice    <= '0;
      n_latched <= '0;
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          mem_we <= 1'b0;
          if (start) begin
            if (start_ok) begin
              n_latched <= n_words;
              indice    <= '0;
              checksum  <= '0;
              done      <= 1'b0;
              erro      <= 1'b0;
              cpu_hold  <= 1'b1;
              estado    <= RECEBE;
            end else begin
              erro     <= 1'b1;
              done     <= 1'b0;
              cpu_hold <= 1'b1;
              estado   <= OCIOSO;
            end
          end
        end
        RECEBE: begin
          if (transfer && word_cheia) begin
            mem_we   <= 1'b1;
            mem_endr <= indice;
            mem_din  <= palavra_prox;
            estado   <= ESCREVE;
          end
        end
        ESCREVE: begin
          mem_we   <= 1'b0;
          checksum <= checksum + mem_din;
          if (ultimo) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            estado   <= FIM;
          end else begin
            indice <= indice + 1'b1;
            estado <= RECEBE;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// Scoreboard bench for carregador_programa: expected memory writes are queued
// as bytes are issued and checked by an independent write monitor.
module tb_carregador_programa;

  typedef struct packed {
    logic [4:0]  endr;
    logic [31:0] din;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  n_words = 6'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_ready;
  logic        mem_we;
  logic [4:0]  mem_endr;
  logic [31:0] mem_din;
  logic        cpu_hold;
  logic        done;
  logic        erro;
  logic [31:0] checksum;

  wr_t         expq[$];
  int          tests = 0;
  int          fails = 0;
  int          writes = 0;
  int          transfers = 0;
  int          w0;
  int          t0;
  logic [4:0]  last_endr = 5'd0;
  logic [31:0] exp_sum = 32'd0;

  carregador_programa dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_words    (n_words),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_endr   (mem_endr),
    .mem_din    (mem_din),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .erro       (erro),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Write monitor: every mem_we pulse must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && byte_valid && byte_ready) transfers++;
    if (rst_n && mem_we) begin
      writes++;
      last_endr = mem_endr;
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: got endr %0d data %h expected no write", mem_endr, mem_din);
      end else begin
        wr_t e;
        e = expq.pop_front();
        if (mem_endr !== e.endr || mem_din !== e.din) begin
          fails++;
          $display("[TB] FAIL write: got endr %0d data %h expected endr %0d data %h",
                   mem_endr, mem_din, e.endr, e.din);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_in = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (byte_ready) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL byte_timeout: got no byte_ready expected byte %h accepted", b);
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushWord(input logic [4:0] endr, input logic [31:0] word);
    wr_t e;
    e.endr = endr;
    e.din = word;
    expq.push_back(e);
    exp_sum = exp_sum + word;
  endtask

  task automatic sendWord(input logic [31:0] word, input int gap);
    for (int k = 0; k < 4; k++) applyStimulus(word[8*k +: 8], gap);
  endtask

  task automatic doStart(input logic [5:0] n);
    start = 1'b1;
    n_words = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    checkOutput("done_reached", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of run expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_checksum", checksum, 32'd0);
    checkOutput("rst_erro", {31'd0, erro}, 32'd0);

    // Two words, valid always high
    w0 = writes;
    doStart(6'd2);
    exp_sum = 32'd0;
    pushWord(5'd0, 32'h00500013);
    sendWord(32'h00500013, 0);
    pushWord(5'd1, 32'h00B505B3);
    sendWord(32'h00B505B3, 0);
    waitDone();
    checkOutput("two_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("two_checksum", checksum, exp_sum);
    checkOutput("two_writes", writes - w0, 32'd2);
    checkOutput("two_queue_empty", expq.size(), 32'd0);

    // One word with gaps between bytes, exact latency to mem_we and done
    w0 = writes;
    t0 = transfers;
    doStart(6'd1);
    exp_sum = 32'd0;
    pushWord(5'd0, 32'hDEADBEEF);
    applyStimulus(8'hEF, 3);
    applyStimulus(8'hBE, 3);
    applyStimulus(8'hAD, 3);
    applyStimulus(8'hDE, 0);
    checkOutput("gap_latency_we", {31'd0, mem_we}, 32'd1);
    checkOutput("gap_done_early", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("gap_done", {31'd0, done}, 32'd1);
    checkOutput("gap_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("gap_checksum", checksum, 32'hDEADBEEF);
    checkOutput("gap_transfers", transfers - t0, 32'd4);
    checkOutput("gap_writes", writes - w0, 32'd1);

    // Illegal word counts
    w0 = writes;
    doStart(6'd0);
    checkOutput("n0_erro", {31'd0, erro}, 32'd1);
    checkOutput("n0_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("n0_byte_ready", {31'd0, byte_ready}, 32'd0);
    doStart(6'd33);
    checkOutput("n33_erro", {31'd0, erro}, 32'd1);
    checkOutput("n33_byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("bad_writes", writes - w0, 32'd0);

    // Full memory load, word i = i*4
    w0 = writes;
    doStart(6'd32);
    checkOutput("full_erro_clear", {31'd0, erro}, 32'd0);
    checkOutput("full_byte_ready", {31'd0, byte_ready}, 32'd1);
    exp_sum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = i * 4;
      pushWord(i[4:0], w);
      sendWord(w, 0);
    end
    waitDone();
    checkOutput("full_checksum", checksum, 32'h000007C0);
    checkOutput("full_last_endr", {27'd0, last_endr}, 32'd31);
    checkOutput("full_writes", writes - w0, 32'd32);
    t0 = transfers;
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    repeat (5) @(posedge clk);
    #1 byte_valid = 1'b0;
    checkOutput("extra_byte", transfers - t0, 32'd0);
    checkOutput("extra_byte_ready", {31'd0, byte_ready}, 32'd0);

    // Reset in the middle of the second word, then restart
    doStart(6'd2);
    pushWord(5'd0, 32'h44332211);
    sendWord(32'h44332211, 0);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h66, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
    checkOutput("mid_rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("mid_rst_checksum", checksum, 32'd0);
    w0 = writes;
    doStart(6'd1);
    exp_sum = 32'd0;
    pushWord(5'd0, 32'h04030201);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h04, 0);
    waitDone();
    checkOutput("restart_checksum", checksum, 32'h04030201);
    checkOutput("restart_writes", writes - w0, 32'd1);
    checkOutput("final_queue_empty", expq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
